lsu_mem_master: RTL and testbench

// - Initiator side of the CPU data-memory interface: takes one load/store per op from the MEM stage and drives a req/ack memory port.
// - Generates a word-aligned address, byte enables and lane-replicated write data; sign/zero-extends read data into a response.
// - Sits between the pipeline MEM stage (stalls it while busy) and the data memory or bus bridge.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_data_align.sv | 59 +++++
 rtl/lsu_mem_master.sv | 142 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory master: op encodings, FSM states,
// byte-lane constants and the alignment predicate used by LSU_ALIGN_CHECK_EN.
package lsu_pkg;

   localparam logic [2:0] ST_W  = 3'd0;
   localparam logic [2:0] ST_H  = 3'd1;
   localparam logic [2:0] ST_B  = 3'd2;

   localparam logic [2:0] LD_W  = 3'd0;
   localparam logic [2:0] LD_H  = 3'd1;
   localparam logic [2:0] LD_HU = 3'd2;
   localparam logic [2:0] LD_B  = 3'd3;
   localparam logic [2:0] LD_BU = 3'd4;

   localparam logic [3:0] BE_WORD    = 4'b1111;
   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } lsu_state_e;

   // Undefined op types behave as word ops, so they need word alignment.
   function automatic logic is_misaligned(input logic       we,
                                          input logic [2:0] op_type,
                                          input logic [1:0] addr_lo);
      logic is_half;
      logic is_byte;
      if (we) begin
         is_half = (op_type == ST_H);
         is_byte = (op_type == ST_B);
      end else begin
         is_half = (op_type == LD_H) || (op_type == LD_HU);
         is_byte = (op_type == LD_B) || (op_type == LD_BU);
      end
      if (is_byte)      return 1'b0;
      else if (is_half) return addr_lo[0];
      else              return |addr_lo;
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane steering: byte enables and replicated write data for
// stores, lane extraction with sign/zero extension for loads.
module lsu_data_align
   import lsu_pkg::*;
(
   input  logic        i_st_we,
   input  logic [2:0]  i_st_type,
   input  logic [1:0]  i_st_addr_lo,
   input  logic [31:0] i_st_wdata,
   input  logic [2:0]  i_ld_type,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic [31:0] i_ld_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ld_data
);

   logic [15:0] w_half;
   logic [7:0]  w_byte;

   always_comb begin
      o_be    = BE_WORD;
      o_wdata = '0;
      if (i_st_we) begin
         case (i_st_type)
            ST_H: begin
               o_be    = i_st_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
               o_wdata = {2{i_st_wdata[15:0]}};
            end
            ST_B: begin
               o_be    = BE_BYTE0 << i_st_addr_lo;
               o_wdata = {4{i_st_wdata[7:0]}};
            end
            default: begin
               o_be    = BE_WORD;
               o_wdata = i_st_wdata;
            end
         endcase
      end
   end

   always_comb begin
      w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
      case (i_ld_addr_lo)
         2'd0:    w_byte = i_ld_rdata[7:0];
         2'd1:    w_byte = i_ld_rdata[15:8];
         2'd2:    w_byte = i_ld_rdata[23:16];
         default: w_byte = i_ld_rdata[31:24];
      endcase
      case (i_ld_type)
         LD_H:    o_ld_data = {{16{w_half[15]}}, w_half};
         LD_HU:   o_ld_data = {16'd0, w_half};
         LD_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
         LD_BU:   o_ld_data = {24'd0, w_byte};
         default: o_ld_data = i_ld_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one op per IDLE->REQ->RESP pass over a req/ack port.
// Define LSU_ALIGN_CHECK_EN to reject misaligned word/half ops without a request.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic              op_we,
   input  logic [2:0]        op_type,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [31:0]       op_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output lsu_state_e        dbg_state
);

   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WD_W:0] TO_V = (WD_W + 1)'(TIMEOUT);

   lsu_state_e        r_state;
   lsu_state_e        w_state_nxt;
   logic              w_accept;
   logic              w_misaligned;
   logic              w_wd_hit;
   logic [WD_W:0]     w_wd_inc;
   logic [WD_W-1:0]   r_wd;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [3:0]        r_mem_be;
   logic [31:0]       r_mem_wdata;
   logic [2:0]        r_ld_type;
   logic [1:0]        r_addr_lo;
   logic [31:0]       r_rsp_rdata;
   logic              r_rsp_err;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [31:0]       w_ld_data;

`ifdef LSU_ALIGN_CHECK_EN
   assign w_misaligned = is_misaligned(op_we, op_type, op_addr[1:0]);
`else
   assign w_misaligned = 1'b0;
`endif

   // Store-side lanes come straight from the op so they can be latched at
   // accept; load extraction works on the latched op against the ack data.
   lsu_data_align u_align (
      .i_st_we      (op_we),
      .i_st_type    (op_type),
      .i_st_addr_lo (op_addr[1:0]),
      .i_st_wdata   (op_wdata),
      .i_ld_type    (r_ld_type),
      .i_ld_addr_lo (r_addr_lo),
      .i_ld_rdata   (mem_rdata),
      .o_be         (w_be),
      .o_wdata      (w_wdata),
      .o_ld_data    (w_ld_data)
   );

   // Watchdog counts the current REQ cycle too, so mem_req lasts TIMEOUT cycles.
   assign w_wd_inc = {1'b0, r_wd} + {{WD_W{1'b0}}, 1'b1};
   assign w_wd_hit = (TIMEOUT != 0) && (w_wd_inc == TO_V);

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (op_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = w_misaligned ? RESP : REQ;
            end
         end
         REQ: begin
            if (mem_ack || w_wd_hit) w_state_nxt = RESP;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_wd        <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_ld_type   <= '0;
         r_addr_lo   <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == REQ && !mem_ack) r_wd <= w_wd_inc[WD_W-1:0];
         else                            r_wd <= '0;
         if (w_accept) begin
            r_mem_we    <= op_we;
            r_mem_addr  <= {op_addr[ADDR_W-1:2], 2'b00};
            r_mem_be    <= w_be;
            r_mem_wdata <= w_wdata;
            r_ld_type   <= op_we ? LD_W : op_type;
            r_addr_lo   <= op_addr[1:0];
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_misaligned;
         end else if (r_state == REQ) begin
            if (mem_ack) begin
               r_rsp_rdata <= r_mem_we ? 32'd0 : w_ld_data;
               r_rsp_err   <= 1'b0;
            end else if (w_wd_hit) begin
               r_rsp_rdata <= '0;
               r_rsp_err   <= 1'b1;
            end
         end
      end
   end

   assign op_ready  = (r_state == IDLE);
   assign mem_req   = (r_state == REQ);
   assign mem_we    = r_mem_we && (r_state == REQ);
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
   assign rsp_valid = (r_state == RESP);
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master (TIMEOUT=4): stores, loads, hold-off,
// watchdog abort, late ack, alignment handling and mid-op reset.
module tb_lsu_mem_master;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic        op_we = 1'b0;
   logic [2:0]  op_type = '0;
   logic [31:0] op_addr = '0;
   logic [31:0] op_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   lsu_state_e  dbg_state;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   lsu_mem_master #(.TIMEOUT(4), .ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_we     (op_we),
      .op_type   (op_type),
      .op_addr   (op_addr),
      .op_wdata  (op_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called #1 after an edge with the DUT in IDLE; returns #1 after the accept edge.
   task automatic drive_op(input logic we, input logic [2:0] ty, input logic [31:0] addr,
                           input logic [31:0] wd, input bit keep_valid);
      chk("op_ready_at_issue", {31'd0, op_ready}, 32'd1);
      op_we = we; op_type = ty; op_addr = addr; op_wdata = wd; op_valid = 1'b1;
      @(posedge clk); #1;
      if (!keep_valid) op_valid = 1'b0;
   endtask

   // Memory responder plus response scoreboard; ack asserted in REQ cycle ack_waits.
   task automatic finish_op(input string tag, input int ack_waits, input bit ack_en,
                            input logic [31:0] rd, input logic [31:0] e_addr, input logic e_we,
                            input logic [3:0] e_be, input logic [31:0] e_wd, input int e_nreq,
                            input logic e_err, input logic [31:0] e_rdata);
      int  n;
      int  nreq;
      bit  got;
      logic [31:0] exp_rd;
      n = 0; nreq = 0; got = 0;
      exp_q.push_back(e_rdata);
      while (!got && n < 40) begin
         mem_ack   = ack_en && (n == ack_waits);
         mem_rdata = rd;
         @(negedge clk);
         n++;
         chk({tag, "_op_ready_busy"}, {31'd0, op_ready}, 32'd0);
         if (rsp_valid) begin
            got = 1;
            exp_rd = exp_q.pop_front();
            chk({tag, "_latency"}, n, e_nreq + 1);
            chk({tag, "_rsp_err"}, {31'd0, rsp_err}, {31'd0, e_err});
            chk({tag, "_rsp_rdata"}, rsp_rdata, exp_rd);
            chk({tag, "_req_in_resp"}, {31'd0, mem_req}, 32'd0);
         end else if (mem_req) begin
            nreq++;
            chk({tag, "_mem_addr"}, mem_addr, e_addr);
            chk({tag, "_mem_be"}, {28'd0, mem_be}, {28'd0, e_be});
            chk({tag, "_mem_we"}, {31'd0, mem_we}, {31'd0, e_we});
            if (e_we) chk({tag, "_mem_wdata"}, mem_wdata, e_wd);
         end
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      if (!got) begin
         void'(exp_q.pop_front());
         chk({tag, "_rsp_seen"}, 32'd0, 32'd1);
      end
      chk({tag, "_req_cycles"}, nreq, e_nreq);
      @(negedge clk);
      chk({tag, "_rsp_pulse_end"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_op_ready_idle"}, {31'd0, op_ready}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int extra;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_op_ready", {31'd0, op_ready}, 32'd1);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      @(posedge clk); #1;

      // stores
      drive_op(1'b1, ST_B, 32'h0000_1002, 32'h0000_00AB, 0);
      finish_op("sb", 0, 1, 32'h0, 32'h0000_1000, 1'b1, 4'b0100, 32'hABAB_ABAB, 1, 1'b0, 32'h0);
      drive_op(1'b1, ST_H, 32'h0000_1006, 32'h1234_BEEF, 0);
      finish_op("sh", 1, 1, 32'h0, 32'h0000_1004, 1'b1, 4'b1100, 32'hBEEF_BEEF, 2, 1'b0, 32'h0);
      drive_op(1'b1, ST_W, 32'h0000_1008, 32'hDEAD_BEEF, 0);
      finish_op("sw", 0, 1, 32'h0, 32'h0000_1008, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1, 1'b0, 32'h0);
      drive_op(1'b1, 3'd5, 32'h0000_100C, 32'h1122_3344, 0);
      finish_op("st_undef", 0, 1, 32'h0, 32'h0000_100C, 1'b1, 4'b1111, 32'h1122_3344, 1, 1'b0, 32'h0);

      // loads; 3 wait cycles lands the ack on the watchdog cycle
      drive_op(1'b0, LD_H, 32'h0000_2002, 32'h0, 0);
      finish_op("lh", 3, 1, 32'h8001_1234, 32'h0000_2000, 1'b0, 4'b1111, 32'h0, 4, 1'b0, 32'hFFFF_8001);
      drive_op(1'b0, LD_HU, 32'h0000_2002, 32'h0, 0);
      finish_op("lhu", 3, 1, 32'h8001_1234, 32'h0000_2000, 1'b0, 4'b1111, 32'h0, 4, 1'b0, 32'h0000_8001);
      drive_op(1'b0, LD_BU, 32'h0000_2001, 32'h0, 0);
      finish_op("lbu", 0, 1, 32'h8001_1234, 32'h0000_2000, 1'b0, 4'b1111, 32'h0, 1, 1'b0, 32'h0000_0012);
      drive_op(1'b0, LD_B, 32'h0000_2003, 32'h0, 0);
      finish_op("lb", 2, 1, 32'h8001_1234, 32'h0000_2000, 1'b0, 4'b1111, 32'h0, 3, 1'b0, 32'hFFFF_FF80);
      drive_op(1'b0, LD_H, 32'h0000_2000, 32'h0, 0);
      finish_op("lh_lo", 0, 1, 32'h8001_1234, 32'h0000_2000, 1'b0, 4'b1111, 32'h0, 1, 1'b0, 32'h0000_1234);
      drive_op(1'b0, 3'd6, 32'h0000_2004, 32'h0, 0);
      finish_op("ld_undef", 1, 1, 32'hCAFE_F00D, 32'h0000_2004, 1'b0, 4'b1111, 32'h0, 2, 1'b0, 32'hCAFE_F00D);

      // op_valid held: second op must wait until after the response
      drive_op(1'b1, ST_W, 32'h0000_4000, 32'h55AA_55AA, 1);
      op_we = 1'b0; op_type = LD_BU; op_addr = 32'h0000_4003;
      finish_op("hold1", 2, 1, 32'h0, 32'h0000_4000, 1'b1, 4'b1111, 32'h55AA_55AA, 3, 1'b0, 32'h0);
      op_valid = 1'b0;
      finish_op("hold2", 0, 1, 32'h9A00_0000, 32'h0000_4000, 1'b0, 4'b1111, 32'h0, 1, 1'b0, 32'h0000_009A);

      // watchdog abort, then a late ack in IDLE
      drive_op(1'b0, LD_W, 32'h0000_5000, 32'h0, 0);
      finish_op("tmo", 0, 0, 32'hFFFF_FFFF, 32'h0000_5000, 1'b0, 4'b1111, 32'h0, 4, 1'b1, 32'h0);
      mem_ack = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("late_ack_req", {31'd0, mem_req}, 32'd0);
         chk("late_ack_rsp", {31'd0, rsp_valid}, 32'd0);
         chk("late_ack_state", {30'd0, dbg_state}, {30'd0, IDLE});
         @(posedge clk); #1;
      end
      mem_ack = 1'b0;

      // misaligned word load
      drive_op(1'b0, LD_W, 32'h0000_3001, 32'h0, 0);
`ifdef LSU_ALIGN_CHECK_EN
      finish_op("lw_mis", 0, 1, 32'h0BAD_F00D, 32'h0, 1'b0, 4'b1111, 32'h0, 0, 1'b1, 32'h0);
`else
      finish_op("lw_mis", 0, 1, 32'h0BAD_F00D, 32'h0000_3000, 1'b0, 4'b1111, 32'h0, 1, 1'b0, 32'h0BAD_F00D);
`endif

      // reset while waiting in REQ
      drive_op(1'b1, ST_W, 32'h0000_6000, 32'h1234_5678, 0);
      @(negedge clk);
      chk("mid_rst_req_before", {31'd0, mem_req}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
      chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_addr", mem_addr, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", {31'd0, op_ready}, 32'd1);
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid || mem_req) extra++;
         @(negedge clk);
      end
      chk("mid_rst_no_rsp", extra, 0);
      @(posedge clk); #1;
      drive_op(1'b1, ST_H, 32'h0000_7001, 32'h0000_C0DE, 0);
`ifdef LSU_ALIGN_CHECK_EN
      finish_op("post_rst_sh", 0, 1, 32'h0, 32'h0, 1'b1, 4'b0011, 32'h0, 0, 1'b1, 32'h0);
`else
      finish_op("post_rst_sh", 0, 1, 32'h0, 32'h0000_7000, 1'b1, 4'b0011, 32'hC0DE_C0DE, 1, 1'b0, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
